// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), sync polarity encodings and the
// line/frame total helpers used by vga_timing_gen.
package vga_timing_pkg;

   localparam int unsigned DEF_H_DISPLAY = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_V_DISPLAY = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;

   localparam logic SYNC_ACTIVE_LOW  = 1'b0;
   localparam logic SYNC_ACTIVE_HIGH = 1'b1;

   function automatic int unsigned h_total(input int unsigned disp, input int unsigned front,
                                           input int unsigned sync, input int unsigned back);
      return disp + front + sync + back;
   endfunction

   function automatic int unsigned v_total(input int unsigned disp, input int unsigned front,
                                           input int unsigned sync, input int unsigned back);
      return disp + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel tick source. With VGA_TIMING_PIX_DIV_EN defined, a modulo-PIX_DIV counter fires the
// tick once every PIX_DIV clocks; otherwise clk is the pixel clock and the tick is constant.
module vga_pix_tick #(
   parameter int unsigned PIX_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

`ifdef VGA_TIMING_PIX_DIV_EN
   localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;

   always_comb begin
      tick  = (div_q == DIV_LAST);
      div_d = tick ? '0 : div_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end
`else
   logic unused_ok;

   assign tick      = 1'b1;
   assign unused_ok = ^{clk, reset, PIX_DIV[0]};
`endif

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters with registered sync, video-enable
// and strobes. Optional pixel divider selected by VGA_TIMING_PIX_DIV_EN (see vga_pix_tick).
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_DISPLAY  = DEF_H_DISPLAY,
   parameter int unsigned H_FRONT    = DEF_H_FRONT,
   parameter int unsigned H_SYNC     = DEF_H_SYNC,
   parameter int unsigned H_BACK     = DEF_H_BACK,
   parameter int unsigned V_DISPLAY  = DEF_V_DISPLAY,
   parameter int unsigned V_FRONT    = DEF_V_FRONT,
   parameter int unsigned V_SYNC     = DEF_V_SYNC,
   parameter int unsigned V_BACK     = DEF_V_BACK,
   parameter logic        H_SYNC_POL = SYNC_ACTIVE_LOW,
   parameter logic        V_SYNC_POL = SYNC_ACTIVE_LOW,
   parameter int unsigned CNT_W      = 10,
   parameter int unsigned PIX_DIV    = 4
) (
   input  logic             clk,
   input  logic             reset,
   output logic             h_sync,
   output logic             v_sync,
   output logic             video_on,
   output logic [CNT_W-1:0] x_loc,
   output logic [CNT_W-1:0] y_loc,
   output logic             pix_stb,
   output logic             line_start,
   output logic             frame_start
);

   localparam int unsigned H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
   localparam int unsigned V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

   if (((64'd1 << CNT_W) < 64'(H_TOTAL)) || ((64'd1 << CNT_W) < 64'(V_TOTAL))) begin : g_err_w
      $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
   end
   if ((H_FRONT == 0) || (H_SYNC == 0) || (H_BACK == 0) ||
       (V_FRONT == 0) || (V_SYNC == 0) || (V_BACK == 0)) begin : g_err_porch
      $error("vga_timing_gen: porch and sync widths must be non-zero");
   end
   if (PIX_DIV < 1) begin : g_err_div
      $error("vga_timing_gen: PIX_DIV must be at least 1");
   end

   localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS     = CNT_W'(H_DISPLAY);
   localparam logic [CNT_W-1:0] V_VIS     = CNT_W'(V_DISPLAY);
   localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_DISPLAY + H_FRONT);
   localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_DISPLAY + V_FRONT);
   localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

   logic             tick;
   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
   logic             h_sync_q, h_sync_d, v_sync_q, v_sync_d, video_on_q, video_on_d;
   logic             pix_stb_q, pix_stb_d, line_start_q, line_start_d;
   logic             frame_start_q, frame_start_d;

   vga_pix_tick #(
      .PIX_DIV(PIX_DIV)
   ) u_pix_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   // Decode is taken from the next counter values so every output moves on the same edge.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
      h_sync_d      = ((h_d >= H_SYNC_LO) && (h_d < H_SYNC_HI)) ? H_SYNC_POL : ~H_SYNC_POL;
      v_sync_d      = ((v_d >= V_SYNC_LO) && (v_d < V_SYNC_HI)) ? V_SYNC_POL : ~V_SYNC_POL;
      video_on_d    = (h_d < H_VIS) && (v_d < V_VIS);
      pix_stb_d     = tick;
      line_start_d  = tick && (h_d == '0);
      frame_start_d = line_start_d && (v_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_q           <= H_LAST;
         v_q           <= V_LAST;
         h_sync_q      <= ~H_SYNC_POL;
         v_sync_q      <= ~V_SYNC_POL;
         video_on_q    <= 1'b0;
         pix_stb_q     <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         h_sync_q      <= h_sync_d;
         v_sync_q      <= v_sync_d;
         video_on_q    <= video_on_d;
         pix_stb_q     <= pix_stb_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign x_loc       = h_q;
   assign y_loc       = v_q;
   assign h_sync      = h_sync_q;
   assign v_sync      = v_sync_q;
   assign video_on    = video_on_q;
   assign pix_stb     = pix_stb_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a small 15x7 instance, both checked
// cycle by cycle against an arithmetic raster model (pixel index -> x, y, windows).
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIX_DIV_EN
   localparam int DIV = 4;
`else
   localparam int DIV = 1;
`endif

   typedef struct packed {
      logic        hs, vs, von, ps, ls, fs;
      logic [31:0] x, y;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_a = 1'b1, rst_b = 1'b1;
   logic       a_hs, a_vs, a_von, a_ps, a_ls, a_fs;
   logic [9:0] a_x, a_y;
   logic       b_hs, b_vs, b_von, b_ps, b_ls, b_fs;
   logic [3:0] b_x, b_y;
   vec_t       act_a, act_b;
   int         ka = 0, kb = 0;
   int         vectors = 0, errors = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .PIX_DIV(4)
   ) u_dut_a (
      .clk        (clk),
      .reset      (rst_a),
      .h_sync     (a_hs),
      .v_sync     (a_vs),
      .video_on   (a_von),
      .x_loc      (a_x),
      .y_loc      (a_y),
      .pix_stb    (a_ps),
      .line_start (a_ls),
      .frame_start(a_fs)
   );

   vga_timing_gen #(
      .H_DISPLAY (8),
      .H_FRONT   (2),
      .H_SYNC    (3),
      .H_BACK    (2),
      .V_DISPLAY (4),
      .V_FRONT   (1),
      .V_SYNC    (1),
      .V_BACK    (1),
      .H_SYNC_POL(1'b1),
      .V_SYNC_POL(1'b0),
      .CNT_W     (4),
      .PIX_DIV   (4)
   ) u_dut_b (
      .clk        (clk),
      .reset      (rst_b),
      .h_sync     (b_hs),
      .v_sync     (b_vs),
      .video_on   (b_von),
      .x_loc      (b_x),
      .y_loc      (b_y),
      .pix_stb    (b_ps),
      .line_start (b_ls),
      .frame_start(b_fs)
   );

   assign act_a = {a_hs, a_vs, a_von, a_ps, a_ls, a_fs, 22'd0, a_x, 22'd0, a_y};
   assign act_b = {b_hs, b_vs, b_von, b_ps, b_ls, b_fs, 28'd0, b_x, 28'd0, b_y};

   // k = clk edges since reset release; pixel p = k/DIV - 1 sits at (p mod HT, (p/HT) mod VT).
   function automatic vec_t model(input int k, input int hd, input int hf, input int hs,
                                  input int hb, input int vd, input int vf, input int vs,
                                  input int vb, input logic hpol, input logic vpol);
      vec_t e;
      int   ht, vt, t, p, x, y;
      ht = hd + hf + hs + hb;
      vt = vd + vf + vs + vb;
      t  = k / DIV;
      if (t == 0) begin
         x = ht - 1;
         y = vt - 1;
         e.ps = 1'b0;
      end else begin
         p = t - 1;
         x = p % ht;
         y = (p / ht) % vt;
         e.ps = ((k % DIV) == 0);
      end
      e.ls  = e.ps && (x == 0);
      e.fs  = e.ls && (y == 0);
      e.von = (t != 0) && (x < hd) && (y < vd);
      e.hs  = ((x >= hd + hf) && (x < hd + hf + hs)) ? hpol : ~hpol;
      e.vs  = ((y >= vd + vf) && (y < vd + vf + vs)) ? vpol : ~vpol;
      e.x   = 32'(x);
      e.y   = 32'(y);
      return e;
   endfunction

   function automatic vec_t exp_a();
      return model(ka, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
   endfunction

   function automatic vec_t exp_b();
      return model(kb, 8, 2, 3, 2, 4, 1, 1, 1, 1'b1, 1'b0);
   endfunction

   task automatic step();
      @(posedge clk);
      if (!rst_a) ka++;
      if (!rst_b) kb++;
      #1;
   endtask

   task automatic test_reset();
      vec_t rv;
      rv = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd799, 32'd524};
      rst_a = 1'b1;
      rst_b = 1'b1;
      ka = 0;
      kb = 0;
      repeat (3) step();
      vectors++;
      if (act_a !== rv) begin
         errors++;
         $display("FAIL reset_a: got %h want %h", act_a, rv);
      end
      vectors++;
      if (act_b !== exp_b()) begin
         errors++;
         $display("FAIL reset_b: got %h want %h", act_b, exp_b());
      end
   endtask

   task automatic test_first_frame();
      vec_t first;
      first = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0};
      rst_a = 1'b0;
      rst_b = 1'b0;
      for (int i = 0; i < DIV; i++) begin
         step();
         vectors++;
         if (act_a !== exp_a()) begin
            errors++;
            $display("FAIL first_a k=%0d: got %h want %h", ka, act_a, exp_a());
         end
      end
      vectors++;
      if (act_a !== first) begin
         errors++;
         $display("FAIL first_frame_a: got %h want %h", act_a, first);
      end
   endtask

   task automatic test_hsync_window();
      int   fall_x = -1, rise_x = -1, von_x = -1, last_ls = -1, min_i = 1 << 30, max_i = 0;
      logic p_hs = 1'b1, p_von = 1'b1;
      bit   dead_a = 0, dead_b = 0;
      for (int c = 1; c <= 1610 * DIV; c++) begin
         step();
         if (!dead_a) begin
            vectors++;
            if (act_a !== exp_a()) begin
               errors++;
               dead_a = 1;
               $display("FAIL hwin_model_a k=%0d: got %h want %h", ka, act_a, exp_a());
            end
         end
         if (!dead_b) begin
            vectors++;
            if (act_b !== exp_b()) begin
               errors++;
               dead_b = 1;
               $display("FAIL hwin_model_b k=%0d: got %h want %h", kb, act_b, exp_b());
            end
         end
         if (p_hs && !a_hs && fall_x < 0) fall_x = int'(a_x);
         if (!p_hs && a_hs && rise_x < 0) rise_x = int'(a_x);
         if (p_von && !a_von && von_x < 0) von_x = int'(a_x);
         if (a_ls) begin
            if (last_ls >= 0) begin
               if (c - last_ls < min_i) min_i = c - last_ls;
               if (c - last_ls > max_i) max_i = c - last_ls;
            end
            last_ls = c;
         end
         p_hs  = a_hs;
         p_von = a_von;
      end
      vectors++;
      if (fall_x !== 656) begin
         errors++;
         $display("FAIL hsync_fall_x: got %0d want 656", fall_x);
      end
      vectors++;
      if (rise_x !== 752) begin
         errors++;
         $display("FAIL hsync_rise_x: got %0d want 752", rise_x);
      end
      vectors++;
      if (von_x !== 640) begin
         errors++;
         $display("FAIL video_on_fall_x: got %0d want 640", von_x);
      end
      vectors++;
      if (min_i !== 800 * DIV || max_i !== 800 * DIV) begin
         errors++;
         $display("FAIL line_period: got %0d..%0d want %0d", min_i, max_i, 800 * DIV);
      end
   endtask

   task automatic test_small_params();
      int   last_fs = -1, min_f = 1 << 30, max_f = 0;
      int   hs_lo = 99, hs_hi = -1, vs_lo = 99, vs_hi = -1;
      logic [3:0] p_x, p_y;
      bit   dead_b = 0;
      p_x = b_x;
      p_y = b_y;
      for (int c = 1; c <= 3 * 105 * DIV; c++) begin
         step();
         if (!dead_b) begin
            vectors++;
            if (act_b !== exp_b()) begin
               errors++;
               dead_b = 1;
               $display("FAIL small_model_b k=%0d: got %h want %h", kb, act_b, exp_b());
            end
         end
         if (b_hs) begin
            if (int'(b_x) < hs_lo) hs_lo = int'(b_x);
            if (int'(b_x) > hs_hi) hs_hi = int'(b_x);
         end
         if (!b_vs) begin
            if (int'(b_y) < vs_lo) vs_lo = int'(b_y);
            if (int'(b_y) > vs_hi) vs_hi = int'(b_y);
         end
         if (b_fs) begin
            vectors++;
            if ({p_x, p_y, b_x, b_y} !== {4'd14, 4'd6, 4'd0, 4'd0}) begin
               errors++;
               $display("FAIL frame_wrap_b: got %h want e600", {p_x, p_y, b_x, b_y});
            end
            if (last_fs >= 0) begin
               if (c - last_fs < min_f) min_f = c - last_fs;
               if (c - last_fs > max_f) max_f = c - last_fs;
            end
            last_fs = c;
         end
         p_x = b_x;
         p_y = b_y;
      end
      vectors++;
      if (hs_lo !== 10 || hs_hi !== 12) begin
         errors++;
         $display("FAIL hsync_high_b: got %0d..%0d want 10..12", hs_lo, hs_hi);
      end
      vectors++;
      if (vs_lo !== 5 || vs_hi !== 5) begin
         errors++;
         $display("FAIL vsync_low_b: got %0d..%0d want 5..5", vs_lo, vs_hi);
      end
      vectors++;
      if (min_f !== 105 * DIV || max_f !== 105 * DIV) begin
         errors++;
         $display("FAIL frame_period_b: got %0d..%0d want %0d", min_f, max_f, 105 * DIV);
      end
   endtask

   task automatic test_mid_reset();
      vec_t rv;
      int   run, hold;
      bit   dead_a;
      rv = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd799, 32'd524};
      for (int it = 0; it < 3; it++) begin
         run    = $urandom_range(1200, 20) * DIV + $urandom_range(DIV - 1, 0);
         hold   = $urandom_range(4, 1);
         dead_a = 0;
         for (int c = 0; c < run; c++) begin
            step();
            if (!dead_a) begin
               vectors++;
               if (act_a !== exp_a()) begin
                  errors++;
                  dead_a = 1;
                  $display("FAIL midrst_run_a k=%0d: got %h want %h", ka, act_a, exp_a());
               end
            end
         end
         rst_a = 1'b1;
         ka    = 0;
         #1;
         vectors++;
         if (act_a !== rv) begin
            errors++;
            $display("FAIL midrst_async_a: got %h want %h", act_a, rv);
         end
         repeat (hold) step();
         vectors++;
         if (act_a !== rv) begin
            errors++;
            $display("FAIL midrst_hold_a: got %h want %h", act_a, rv);
         end
         rst_a = 1'b0;
         for (int c = 0; c < DIV; c++) begin
            step();
            vectors++;
            if (act_a !== exp_a()) begin
               errors++;
               $display("FAIL midrst_release_a k=%0d: got %h want %h", ka, act_a, exp_a());
            end
         end
         vectors++;
         if ({a_fs, a_x, a_y} !== {1'b1, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL midrst_frame_start_a: got %h want 100000", {a_fs, a_x, a_y});
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_hsync_window();
      test_small_params();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
